// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the PDM CIC decimator.
package cic_pkg;

    localparam int CIC_OUT_W = 17;

    // Number of bits needed to count 0..r-1; r is a power of two.
    function automatic int cic_log2(input int r);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < r) n = i + 1;
        end
        return n;
    endfunction

    function automatic int cic_width(input int n, input int r);
        return n * cic_log2(r) + 1;
    endfunction

    // Positive result is a right shift, negative a left shift.
    function automatic int cic_out_shift(input int w);
        return w - CIC_OUT_W;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: out <= in - in_delayed, advancing only on in_valid.
import cic_pkg::*;

module cic_comb_stage #(
    parameter int W = cic_width(4, 16)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [W-1:0] dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - dly;
                dly      <= in_data;
            end
        end
    end

endmodule

// File: rtl/cic_pdm_decimator.sv
// N-stage CIC decimator for 1-bit PDM, 17-bit unsigned output every R PDM bits.
// Optional macro CIC_WARMUP_MASK_EN hides out_valid for the first N+1 samples after reset.
import cic_pkg::*;

module cic_pdm_decimator #(
    parameter int N = 4,
    parameter int R = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pdm_in,
    input  logic                 pdm_en,
    output logic [CIC_OUT_W-1:0] y_out,
    output logic                 out_valid
);

    localparam int W         = cic_width(N, R);
    localparam int CNT_W     = cic_log2(R);
    localparam int OUT_SHIFT = cic_out_shift(W);

    logic [W-1:0]     integ_p0 [N];
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [W-1:0]     snap_p1;
    logic             snap_vld_p1;
    logic [W-1:0]     comb_data [N+1];
    logic [N:0]       comb_vld;
    logic             out_gate;

    function automatic logic [CIC_OUT_W-1:0] scale_out(input logic [W-1:0] c);
        logic [W+CIC_OUT_W-1:0] wide;
        wide = {{CIC_OUT_W{1'b0}}, c};
        if (OUT_SHIFT >= 0) wide = wide >> OUT_SHIFT;
        else                wide = wide << (-OUT_SHIFT);
        return wide[CIC_OUT_W-1:0];
    endfunction

    assign tick = pdm_en && (cnt == CNT_W'(R - 1));

    // Stage p0: integrators run at the PDM rate; modulo-2^W wrap is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) integ_p0[k] <= '0;
            cnt         <= '0;
            snap_p1     <= '0;
            snap_vld_p1 <= 1'b0;
        end else begin
            snap_vld_p1 <= tick;
            if (tick) snap_p1 <= integ_p0[N-1];
            if (pdm_en) begin
                cnt         <= cnt + 1'b1;
                integ_p0[0] <= integ_p0[0] + W'(pdm_in);
                for (int k = 1; k < N; k++) integ_p0[k] <= integ_p0[k] + integ_p0[k-1];
            end
        end
    end

    // Stage p1..pN: comb chain at the decimated rate, driven only by the valid shift.
    assign comb_data[0] = snap_p1;
    assign comb_vld[0]  = snap_vld_p1;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(.W(W)) u_comb (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (comb_vld[k]),
            .in_data   (comb_data[k]),
            .out_valid (comb_vld[k+1]),
            .out_data  (comb_data[k+1])
        );
    end

`ifdef CIC_WARMUP_MASK_EN
    logic [2:0] warm_cnt;

    assign out_gate = (warm_cnt == 3'(N + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         warm_cnt <= '0;
        else if (comb_vld[N] && !out_gate) warm_cnt <= warm_cnt + 3'd1;
    end
`else
    assign out_gate = 1'b1;
`endif

    // Stage pN+1: scale to the 17-bit output and raise out_valid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= comb_vld[N] && out_gate;
            if (comb_vld[N]) y_out <= scale_out(comb_data[N]);
        end
    end

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Scoreboard bench: expected samples come from a direct convolution with the CIC impulse response.
module tb_cic_pdm_decimator;

    localparam int N  = 4;
    localparam int R  = 16;
    localparam int W  = 17;
    localparam int HL = N * (R - 1) + 1;
`ifdef CIC_WARMUP_MASK_EN
    localparam int MASKED = N + 1;
`else
    localparam int MASKED = 0;
`endif

    typedef struct {
        logic [16:0] val;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdm_in;
    logic        pdm_en;
    logic [16:0] y_out;
    logic        out_valid;

    exp_t   sbq[$];
    exp_t   e;
    int     hist[$];
    longint h[HL];
    int     cyc = 0;
    int     bitcnt = 0;
    int     ticks = 0;
    int     checks = 0;
    int     passed = 0;
    int     pulses = 0;

    cic_pdm_decimator #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_in    (pdm_in),
        .pdm_en    (pdm_en),
        .y_out     (y_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // y[t] = sum_j h[j] * x[t-N-j] mod 2^W; the N-bit delay comes from the integrator chain.
    function automatic logic [16:0] model(input int t);
        longint acc;
        acc = 0;
        for (int j = 0; j < HL; j++) begin
            int idx;
            idx = t - N - j;
            if (idx >= 0) acc += h[j] * longint'(hist[idx]);
        end
        return 17'(acc % (longint'(1) << W));
    endfunction

    // Monitor: every out_valid must match the queue head, both value and cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pulses++;
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got out_valid=1 y_out=%0h, required no output (cycle %0d)", y_out, cyc);
            end else begin
                e = sbq.pop_front();
                check("sample_value", 32'(y_out), 32'(e.val));
                check("sample_time", cyc, e.due);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checks++;
            $display("FAIL missing_valid: got out_valid=%b, required 1 at cycle %0d", out_valid, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic drive(input logic b, input logic en);
        exp_t x;
        @(negedge clk);
        pdm_in = b;
        pdm_en = en;
        if (en) begin
            hist.push_back(int'(b));
            if (bitcnt == R - 1) begin
                ticks++;
                if (ticks > MASKED) begin
                    x.val = model(hist.size() - 1);
                    x.due = cyc + N + 2;
                    sbq.push_back(x);
                end
            end
            bitcnt = (bitcnt + 1) % R;
        end
    endtask

    task automatic send(input logic b, input int gap);
        drive(b, 1'b1);
        repeat (gap) drive(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        pdm_en = 1'b0;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d samples pending, required 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pdm_en = 1'b0;
        sbq.delete();
        hist.delete();
        bitcnt = 0;
        ticks  = 0;
        #1;
        check("reset_y_out", 32'(y_out), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        longint tmp[HL];
        int len;

        rst    = 1'b1;
        pdm_in = 1'b0;
        pdm_en = 1'b0;

        // Impulse response: boxcar of length R convolved with itself N times.
        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (N) begin
            for (int i = 0; i < HL; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            h = tmp;
            len += R - 1;
        end

        do_reset();

        for (int i = 0; i < 200; i++) send(1'b1, 3);
        drain();
        check("full_scale", 32'(y_out), 32'h10000);

        for (int i = 0; i < 200; i++) send(1'b0, 3);
        drain();
        check("all_zero", 32'(y_out), 32'h0);

        for (int i = 0; i < 200; i++) send(1'(i % 2), 1);
        drain();
        check("half_scale", 32'(y_out), 32'h08000);

        do_reset();
        pulses = 0;
        for (int i = 0; i < 64; i++) drive(1'($urandom_range(0, 1)), 1'b1);
        drain();
        check("b2b_pulse_count", pulses, (4 > MASKED) ? 4 - MASKED : 0);

        for (int i = 0; i < 300; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        drain();

        // Reset two clocks into the comb drain of a full-scale tick.
        repeat (3 * R) drive(1'b1, 1'b1);
        while (bitcnt != R - 1) drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(posedge clk);
        #1 pdm_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_y_out", 32'(y_out != 17'h0), 32'h1);
        do_reset();
        pulses = 0;
        for (int i = 0; i < R; i++) drive(1'b1, 1'b1);
        drain();
        check("post_reset_pulses", pulses, (1 > MASKED) ? 1 : 0);

`ifdef CIC_WARMUP_MASK_EN
        do_reset();
        pulses = 0;
        for (int i = 0; i < (N + 2) * R; i++) drive(1'b1, 1'b1);
        drain();
        check("mask_first_pulse_count", pulses, 1);
        check("mask_first_value", 32'(y_out), 32'h10000);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
